// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop synchronizer, debouncer, press/release strobes and an
// optional hold-to-repeat strobe generator.
// Define BUTTON_CONDITIONER_REPEAT_EN to build the auto-repeat FSM; otherwise
// o_Repeat_Pulse is tied low and no repeat logic exists.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES      = 4,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 10,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 3
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Button,
  output logic o_Level,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Repeat_Pulse
);

  // Counter only has to hold 0..DEBOUNCE_CYCLES-1; the terminal count toggles and clears.
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  logic           sync1_q, sync2_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;

  // Two-flop synchronizer for the raw asynchronous switch input.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_Button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples, toggle the level on the last one.
  always_comb begin
    db_cnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and registered strobes.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_Level         = level_q;
  assign o_Press_Pulse   = press_q;
  assign o_Release_Pulse = release_q;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  // Loaded one edge after the press strobe, so the remaining delay is one less.
  localparam logic [RepW-1:0] RepDelayLoad  = RepW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RepW-1:0] RepPeriodLoad = RepW'(REPEAT_PERIOD_CYCLES);
  localparam logic [RepW-1:0] RepOne        = RepW'(1);

  typedef enum logic [1:0] {StIdle, StHoldDelay, StRepeating} rep_state_e;

  rep_state_e      state_q, state_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            repeat_q, repeat_d;

  // Repeat FSM: rep_cnt holds edges remaining until the next repeat strobe.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    repeat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press_q) begin
          state_d   = StHoldDelay;
          rep_cnt_d = RepDelayLoad;
        end
      end
      StHoldDelay, StRepeating: begin
        if (rep_cnt_q <= RepOne) begin
          repeat_d  = 1'b1;
          state_d   = StRepeating;
          rep_cnt_d = RepPeriodLoad;
        end else begin
          rep_cnt_d = rep_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        rep_cnt_d = '0;
      end
    endcase
    // A falling level wins over everything, including a strobe due on the same edge.
    if (!level_d) begin
      state_d   = StIdle;
      rep_cnt_d = '0;
      repeat_d  = 1'b0;
    end
  end

  // Repeat FSM state, counter and registered strobe.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= StIdle;
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_Repeat_Pulse = repeat_q;
`else
  // Repeat timing parameters are meaningless without the repeat FSM.
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY_CYCLES[0], REPEAT_PERIOD_CYCLES[0]};
  assign o_Repeat_Pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Repeat expectations follow BUTTON_CONDITIONER_REPEAT_EN.
module tb_button_conditioner;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic button = 1'b0;
  logic level, press, rel, rep;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (10),
    .REPEAT_PERIOD_CYCLES (3)
  ) dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_Button        (button),
    .o_Level         (level),
    .o_Press_Pulse   (press),
    .o_Release_Pulse (rel),
    .o_Repeat_Pulse  (rep)
  );

  typedef struct {
    string name;
    logic  btn;
    logic  level;
    logic  press;
    logic  rel;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic b, logic l, logic p, logic r);
    vec_t v;
    v.name  = n;
    v.btn   = b;
    v.level = l;
    v.press = p;
    v.rel   = r;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic el, logic ep, logic er, logic erp);
    n_checks++;
    if ({level, press, rel, rep} !== {el, ep, er, erp}) begin
      n_errors++;
      $display("FAIL %s @%0t: got level/press/release/repeat=%b%b%b%b expected %b%b%b%b",
               name, $time, level, press, rel, rep, el, ep, er, erp);
    end
  endtask

  // Raw press from idle: strobe exactly on the 6th edge.
  task automatic press_seq(string name);
    button = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check(name, e == 6, e == 6, 1'b0, 1'b0);
    end
  endtask

  // Called right after the press-strobe edge P; k counts edges after P.
  // The level falls at edge P+f, so raw release is applied 5 edges earlier.
  task automatic hold_and_release(string name, int f, int total);
    for (int k = 1; k <= total; k++) begin
      button = (k < f - 5);
      tick();
      check(name, k < f, 1'b0, k == f,
            RepEn && (k >= 10) && ((k - 10) % 3 == 0) && (k < f));
    end
  endtask

  initial begin
    // Clean press and release.
    for (int i = 0; i < 5; i++) add("clean_pre", 1'b1, 1'b0, 1'b0, 1'b0);
    add("clean_press", 1'b1, 1'b1, 1'b1, 1'b0);
    add("clean_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add("clean_rel_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    add("clean_release", 1'b0, 1'b0, 1'b0, 1'b1);
    add("clean_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // Bounce 1-1-0-0-1-1-0-0 then stable press.
    for (int i = 0; i < 8; i++) add("bounce", (i % 4) < 2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add("bounce_settle", 1'b1, 1'b0, 1'b0, 1'b0);
    add("bounce_press", 1'b1, 1'b1, 1'b1, 1'b0);
    add("bounce_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add("bounce_rel_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    add("bounce_release", 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // One-sample and three-sample glitches must be filtered.
    add("glitch1", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add("glitch1_after", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add("glitch3", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add("glitch3_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset with no clock edge.
    #1 rst_n = 1'b0;
    #1 check("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_clocked", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      button = vecs[i].btn;
      tick();
      check(vecs[i].name, vecs[i].level, vecs[i].press, vecs[i].rel, 1'b0);
    end

    // Long hold; level falls on an edge where a repeat would otherwise fire (P+28).
    press_seq("hold_press");
    hold_and_release("hold_long", 28, 31);

    // Release with level falling at P+14: repeats at P+10, P+13 only.
    press_seq("rel_press");
    hold_and_release("rel_p14", 14, 20);

    // Reset mid-hold at P+12, button kept pressed.
    press_seq("rst_press");
    button = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("rst_pre_hold", 1'b1, 1'b0, 1'b0, RepEn && (k == 10));
    end
    #2 rst_n = 1'b0;
    #1 check("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    press_seq("rst_repress");
    hold_and_release("rst_rehold", 14, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
